imem_controller: RTL and testbench

IMEM_CONTROLLER -- requirements
Module: imem_controller

---
 rtl/riscv_pkg.sv | 12 +
 rtl/imem_controller.sv | 126 ++++++++++++
 tb/tb_imem_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared state encoding and instruction constants
package riscv_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

    // Canonical RISC-V NOP (addi x0, x0, 0) returned for bad fetch addresses
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_controller.sv
// rtl/imem_controller.sv - instruction memory front-end with boot loader and fetch port
module imem_controller
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic                  addr_err,
    input  logic                  load_valid,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  load_done,
    output logic                  cpu_hold,
    output logic [DEPTH_LOG2:0]   words_loaded,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [DEPTH_LOG2:0]   WL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] NOP_W  = DATA_WIDTH'(NOP_INSTR);

    imem_state_t state, state_next;

    logic                  rd_good;     // memory read in flight, data arrives this cycle
    logic                  rd_bad;      // rejected fetch in flight, answer with NOP
    logic [DATA_WIDTH-1:0] data_q;      // last delivered instruction, held between fetches
    logic [DEPTH_LOG2:0]   wl_q;

    logic wr_acc;
    logic wr_ok;
    logic fetch_acc;
    logic fetch_ok;

    // Word-aligned and inside the array: only such addresses may touch memory
    assign wr_ok    = (load_addr[1:0] == 2'b00) && ((load_addr >> (DEPTH_LOG2 + 2)) == '0);
    assign fetch_ok = (fetch_addr[1:0] == 2'b00) && ((fetch_addr >> (DEPTH_LOG2 + 2)) == '0);

    // State register; reset always lands in BOOT with the core held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshakes and memory port; everything input-driven is forced idle in reset
    always_comb begin
        state_next  = state;
        load_ready  = 1'b0;
        fetch_ready = 1'b0;
        wr_acc      = 1'b0;
        fetch_acc   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (rst_n) begin
            load_ready = 1'b1;
            case (state)
                BOOT:    if (load_done) state_next = RUN;
                RUN:     fetch_ready = !load_valid;
                default: state_next = BOOT;
            endcase
            wr_acc    = load_valid && load_ready;
            fetch_acc = fetch_req && fetch_ready;
            if (wr_acc) begin
                mem_en    = 1'b1;
                mem_we    = wr_ok;
                mem_addr  = load_addr[DEPTH_LOG2+1:2];
                mem_wdata = load_data;
            end else if (fetch_acc && fetch_ok) begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr[DEPTH_LOG2+1:2];
            end
        end
    end

    // One-cycle read pipeline tracking what the next cycle must present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_good <= 1'b0;
            rd_bad  <= 1'b0;
        end else begin
            rd_good <= fetch_acc && fetch_ok;
            rd_bad  <= fetch_acc && !fetch_ok;
        end
    end

    // Keep the delivered word so instr_data is stable while no fetch completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (instr_valid) begin
            data_q <= instr_data;
        end
    end

    // Count good loader writes, sticking at the array size
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wl_q <= '0;
        end else if (wr_acc && wr_ok && (wl_q != WL_MAX)) begin
            wl_q <= wl_q + 1'b1;
        end
    end

    assign instr_valid  = rd_good || rd_bad;
    assign addr_err     = rd_bad;
    assign instr_data   = rd_good ? mem_rdata : (rd_bad ? NOP_W : data_q);
    assign cpu_hold     = (state == BOOT);
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_controller.sv
// tb/tb_imem_controller.sv - self-checking bench for imem_controller
module tb_imem_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        addr_err;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        cpu_hold;
    logic [10:0] words_loaded;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int n_cmp = 0;
    int n_err = 0;
    int we_count = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        lv;
        logic [31:0] la;
        logic [31:0] ld;
        logic        done;
        logic        exp_we;
        logic [10:0] exp_wl;
    } vec_t;
    vec_t tbl[6];

    logic [31:0] mem_arr [1024];
    logic [31:0] ref_mem [1024];

    imem_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .instr_valid(instr_valid), .instr_data(instr_data), .addr_err(addr_err),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done), .cpu_hold(cpu_hold),
        .words_loaded(words_loaded), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // External synchronous memory with registered read data
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop on delivered instructions, push on accepted fetches
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) we_count++;
        if (instr_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: instr_valid with nothing outstanding, data 0x%0h", instr_data);
            end else begin
                e = sb.pop_front();
                check("sb_instr_data", 64'(instr_data), 64'(e.data));
                check("sb_addr_err", 64'(addr_err), 64'(e.err));
            end
        end
        if (fetch_req && fetch_ready) begin
            if (fetch_addr[1:0] != 2'b00 || fetch_addr >= 32'd4096) begin
                e.data = 32'h0000_0013;
                e.err  = 1'b1;
            end else begin
                e.data = ref_mem[fetch_addr[11:2]];
                e.err  = 1'b0;
            end
            sb.push_back(e);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        tbl[0] = '{1'b1, 32'd0,      32'h11,   1'b0, 1'b1, 11'd1};
        tbl[1] = '{1'b1, 32'd4,      32'h22,   1'b0, 1'b1, 11'd2};
        tbl[2] = '{1'b1, 32'd2,      32'hdead, 1'b0, 1'b0, 11'd2};
        tbl[3] = '{1'b1, 32'h1000,   32'hbeef, 1'b0, 1'b0, 11'd2};
        tbl[4] = '{1'b1, 32'd8,      32'h33,   1'b0, 1'b1, 11'd3};
        tbl[5] = '{1'b1, 32'd12,     32'h44,   1'b1, 1'b1, 11'd4};

        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;

        // Reset state
        #12;
        check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr_data", 64'(instr_data), 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
        check("rst_words_loaded", 64'(words_loaded), 64'd0);
        check("rst_load_ready", 64'(load_ready), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("boot_load_ready", 64'(load_ready), 64'd1);
        check("boot_fetch_ready", 64'(fetch_ready), 64'd0);
        check("boot_cpu_hold", 64'(cpu_hold), 64'd1);
        we_count = 0;

        // Loader table, including a misaligned and an out-of-range write
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            load_valid = tbl[i].lv; load_addr = tbl[i].la;
            load_data = tbl[i].ld; load_done = tbl[i].done;
            @(negedge clk);
            check($sformatf("ld%0d_mem_we", i), 64'(mem_we), 64'(tbl[i].exp_we));
            check($sformatf("ld%0d_mem_en", i), 64'(mem_en), 64'd1);
            check($sformatf("ld%0d_cpu_hold", i), 64'(cpu_hold), 64'd1);
            if (tbl[i].exp_we) begin
                check($sformatf("ld%0d_mem_addr", i), 64'(mem_addr), 64'(tbl[i].la >> 2));
                check($sformatf("ld%0d_mem_wdata", i), 64'(mem_wdata), 64'(tbl[i].ld));
                ref_mem[tbl[i].la[11:2]] = tbl[i].ld;
            end
            @(posedge clk); #1;
            load_valid = 1'b0; load_done = 1'b0;
            check($sformatf("ld%0d_words_loaded", i), 64'(words_loaded), 64'(tbl[i].exp_wl));
        end
        check("run_cpu_hold_fell", 64'(cpu_hold), 64'd0);
        @(negedge clk);
        check("we_pulse_count", 64'(we_count), 64'd4);
        check("idle_mem_en", 64'(mem_en), 64'd0);
        check("idle_mem_we", 64'(mem_we), 64'd0);
        check("run_fetch_ready", 64'(fetch_ready), 64'd1);

        // Back-to-back fetches 0,4,8
        @(posedge clk); #1 fetch_req = 1'b1; fetch_addr = 32'd0;
        @(negedge clk);
        check("f0_mem_en", 64'(mem_en), 64'd1);
        check("f0_mem_we", 64'(mem_we), 64'd0);
        check("f0_mem_addr", 64'(mem_addr), 64'd0);
        check("f0_no_valid_yet", 64'(instr_valid), 64'd0);
        @(posedge clk); #1 fetch_addr = 32'd4;
        @(negedge clk); check("b2b_valid0", 64'(instr_valid), 64'd1);
        @(posedge clk); #1 fetch_addr = 32'd8;
        @(negedge clk); check("b2b_valid1", 64'(instr_valid), 64'd1);
        @(posedge clk); #1 fetch_req = 1'b0;
        @(negedge clk); check("b2b_valid2", 64'(instr_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_valid_low", 64'(instr_valid), 64'd0);
        check("idle_data_hold", 64'(instr_data), 64'h33);

        // Misaligned and out-of-range fetches
        @(posedge clk); #1 fetch_req = 1'b1; fetch_addr = 32'h2;
        @(negedge clk); check("bad2_mem_en", 64'(mem_en), 64'd0);
        @(posedge clk); #1 fetch_addr = 32'h1000;
        @(negedge clk);
        check("bad1000_mem_en", 64'(mem_en), 64'd0);
        check("bad2_addr_err", 64'(addr_err), 64'd1);
        @(posedge clk); #1 fetch_req = 1'b0;
        @(negedge clk); check("bad1000_addr_err", 64'(addr_err), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_cleared", 64'(addr_err), 64'd0);
        check("nop_hold", 64'(instr_data), 64'h13);

        // Loader write and fetch in the same cycle: write wins
        @(posedge clk); #1;
        load_valid = 1'b1; load_addr = 32'd16; load_data = 32'h55;
        fetch_req = 1'b1; fetch_addr = 32'd16;
        @(negedge clk);
        check("prio_fetch_ready", 64'(fetch_ready), 64'd0);
        check("prio_load_ready", 64'(load_ready), 64'd1);
        check("prio_mem_we", 64'(mem_we), 64'd1);
        ref_mem[4] = 32'h55;
        @(posedge clk); #1 load_valid = 1'b0;
        @(negedge clk);
        check("prio_fetch_next", 64'(fetch_ready), 64'd1);
        check("prio_fetch_mem_en", 64'(mem_en), 64'd1);
        check("prio_fetch_addr", 64'(mem_addr), 64'd4);
        @(posedge clk); #1 fetch_req = 1'b0;
        check("run_words_loaded", 64'(words_loaded), 64'd5);
        @(negedge clk);
        @(posedge clk); #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Reset right after an accepted fetch discards it
        @(posedge clk); #1 fetch_req = 1'b1; fetch_addr = 32'd4;
        @(negedge clk); check("pre_rst_accept", 64'(fetch_ready), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0; fetch_req = 1'b0;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_fetch_valid%0d", k), 64'(instr_valid), 64'd0);
        end
        check("rst_fetch_wl", 64'(words_loaded), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_fetch_boot", 64'(fetch_ready), 64'd0);
        check("rst_fetch_hold", 64'(cpu_hold), 64'd1);
        check("rst_fetch_valid_after", 64'(instr_valid), 64'd0);

        // Saturation: 1025 good writes
        for (int i = 0; i <= 1024; i++) begin
            @(posedge clk); #1;
            load_valid = 1'b1;
            load_addr  = (i == 1024) ? 32'd0 : 32'(i * 4);
            load_data  = 32'(i);
            if (i == 1024) begin
                @(negedge clk);
                check("sat_before_last", 64'(words_loaded), 64'd1024);
            end
        end
        @(posedge clk); #1 load_valid = 1'b0;
        check("sat_words_loaded", 64'(words_loaded), 64'd1024);

        // Reset in the middle of loading restarts the count
        @(posedge clk); #1 load_valid = 1'b1; load_addr = 32'd0;
        @(posedge clk); #1 rst_n = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        check("midload_rst_wl", 64'(words_loaded), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midload_post_wl", 64'(words_loaded), 64'd0);
        check("midload_post_hold", 64'(cpu_hold), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
